// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data_mem between port 0 (core LSU) and port 1 (loader/DMA), one access at a time.
// Latency gnt->rsp_valid: 4 cycles nominal, 1 for out-of-range, TIMEOUT+2 on a memory timeout.
// Backpressure: req is a held level; gnt fires only in IDLE, so a busy arbiter just withholds gnt.
module dmem_arbiter #(
   parameter int ADDRW   = 10,
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [1:0]  req_we,
   input  logic [31:0] req_addr0,
   input  logic [31:0] req_addr1,
   input  logic [31:0] req_wdata0,
   input  logic [31:0] req_wdata1,
   output logic [1:0]  gnt,
   output logic [1:0]  rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_re,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout,
   input  logic        mem_valid
);
   localparam int CNTW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] { IDLE, ISSUE, WAIT, RESP } state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } acc_t;

   state_t          state;
   logic            last;
   logic            owner;
   logic            we_l;
   logic [CNTW-1:0] wait_cnt;
   logic            sel;
   acc_t            sel_acc;
   logic            sel_ok;
   logic [1:0]      owner_oh;

   // Round-robin pick: on contention the port that was not granted last wins.
   always_comb begin
      sel = 1'b0;
      if (req == 2'b11)
         sel = ~last;
      else if (req[1])
         sel = 1'b1;

      sel_acc = '0;
      if (sel) begin
         sel_acc.we    = req_we[1];
         sel_acc.addr  = req_addr1;
         sel_acc.wdata = req_wdata1;
      end else begin
         sel_acc.we    = req_we[0];
         sel_acc.addr  = req_addr0;
         sel_acc.wdata = req_wdata0;
      end

      sel_ok = (sel_acc.addr >> ADDRW) == 32'd0;

      gnt = 2'b00;
      if (state == IDLE && !rst && req != 2'b00)
         gnt = sel ? 2'b10 : 2'b01;
   end

   assign owner_oh = owner ? 2'b10 : 2'b01;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= 1'b1;
         owner     <= 1'b0;
         we_l      <= 1'b0;
         wait_cnt  <= '0;
         rsp_valid <= 2'b00;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_din   <= 32'd0;
      end else begin
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         rsp_valid <= 2'b00;
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  owner    <= sel;
                  last     <= sel;
                  we_l     <= sel_acc.we;
                  mem_addr <= sel_acc.addr;
                  mem_din  <= sel_acc.wdata;
                  if (sel_ok) begin
                     state  <= ISSUE;
                     mem_re <= ~sel_acc.we;
                     mem_we <= sel_acc.we;
                  end else begin
                     // Out-of-range never reaches data_mem; answer straight away.
                     state     <= RESP;
                     rsp_valid <= sel ? 2'b10 : 2'b01;
                     rsp_rdata <= 32'd0;
                     rsp_err   <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (mem_valid) begin
                  state     <= RESP;
                  rsp_valid <= owner_oh;
                  rsp_rdata <= we_l ? 32'd0 : mem_dout;
                  rsp_err   <= 1'b0;
               end else if (wait_cnt == CNTW'(TIMEOUT - 1)) begin
                  state     <= RESP;
                  rsp_valid <= owner_oh;
                  rsp_rdata <= 32'd0;
                  rsp_err   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNTW'(1);
               end
            end
            RESP: begin
               rsp_rdata <= 32'd0;
               rsp_err   <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized two-port run against a transaction-level model.
module tb_dmem_arbiter;
   localparam int ADDRW   = 10;
   localparam int TIMEOUT = 15;

   logic        clk, rst;
   logic [1:0]  req, req_we, gnt, rsp_valid;
   logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
   logic [31:0] rsp_rdata, mem_addr, mem_din, mem_dout;
   logic        rsp_err, mem_re, mem_we, mem_valid;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int mem_lat  = 2;
   int pend_cnt;
   logic [31:0] pend_dat;
   logic [31:0] mem_arr [1024];
   logic [31:0] ref_mem [1024];

   dmem_arbiter #(.ADDRW(ADDRW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .mem_valid(mem_valid)
   );

   function automatic logic [31:0] init_val(input int i);
      return 32'hA500_0000 ^ (32'(i) * 32'h0001_0001);
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // data_mem stand-in: sees re/we mid-cycle, answers mem_lat negedges later (0 = never answers).
   initial begin
      for (int i = 0; i < 1024; i++) mem_arr[i] = init_val(i);
      mem_valid = 1'b0;
      mem_dout  = 32'd0;
      pend_cnt  = 0;
      pend_dat  = 32'd0;
      forever begin
         @(negedge clk);
         mem_valid = 1'b0;
         mem_dout  = $urandom;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               mem_valid = 1'b1;
               mem_dout  = pend_dat;
            end
         end
         if (mem_re || mem_we) begin
            if (mem_we) begin
               mem_arr[mem_addr[9:0]] = mem_din;
               pend_dat = $urandom;
            end else begin
               pend_dat = mem_arr[mem_addr[9:0]];
            end
            pend_cnt = mem_lat;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic apply_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      req = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Single access on one port; reports latency from gnt to rsp_valid and what data_mem saw.
   task automatic do_access(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int lat, output int rlat, output int op_off, output int n_re,
                            output int n_we, output logic [1:0] gbits, output logic [1:0] rv,
                            output logic [31:0] rd, output logic er);
      int t_g;
      int k;
      t_g = -1; rlat = -1; op_off = -1; n_re = 0; n_we = 0;
      gbits = 2'b00; rv = 2'b00; rd = 32'd0; er = 1'b0;
      mem_lat = lat;
      @(posedge clk); #1;
      req[p]    = 1'b1;
      req_we[p] = we;
      if (p == 0) begin req_addr0 = addr; req_wdata0 = wdata; end
      else begin req_addr1 = addr; req_wdata1 = wdata; end
      k = 0;
      while (rlat < 0 && k < 60) begin
         @(negedge clk);
         if (gnt != 2'b00 && t_g < 0) begin t_g = cyc; gbits = gnt; end
         if (mem_re) n_re++;
         if (mem_we) n_we++;
         if ((mem_re || mem_we) && t_g >= 0) op_off = cyc - t_g;
         if (rsp_valid != 2'b00) begin
            rlat = (t_g >= 0) ? cyc - t_g : 999;
            rv = rsp_valid; rd = rsp_rdata; er = rsp_err;
         end
         @(posedge clk); #1;
         if (t_g >= 0) req[p] = 1'b0;
         k++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 2'b11; req_we = 2'b01;
      req_addr0 = 32'd1; req_addr1 = 32'd2; req_wdata0 = 32'h1111; req_wdata1 = 32'h2222;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (gnt !== 2'b00) begin n_errors++; $display("FAIL rst_gnt: got %b want 00", gnt); end
      n_checks++; if (rsp_valid !== 2'b00) begin n_errors++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
      n_checks++; if ({rsp_err, mem_re, mem_we} !== 3'b000) begin n_errors++; $display("FAIL rst_flags: err/re/we got %b want 000", {rsp_err, mem_re, mem_we}); end
      n_checks++; if ({rsp_rdata, mem_addr, mem_din} !== 96'd0) begin n_errors++; $display("FAIL rst_data: rdata %h addr %h din %h want 0", rsp_rdata, mem_addr, mem_din); end
      @(posedge clk); #1;
      req = 2'b00; rst = 1'b0;
   endtask

   task automatic test_read();
      int rlat, off, nre, nwe; logic [1:0] g, rv; logic [31:0] rd; logic er;
      mem_arr[5] = 32'hDEAD_BEEF;
      do_access(0, 1'b0, 32'd5, 32'd0, 2, rlat, off, nre, nwe, g, rv, rd, er);
      n_checks++; if (g !== 2'b01) begin n_errors++; $display("FAIL read_gnt: got %b want 01", g); end
      n_checks++; if (rlat !== 4) begin n_errors++; $display("FAIL read_latency: got %0d want 4", rlat); end
      n_checks++; if (off !== 1 || nre !== 1 || nwe !== 0) begin n_errors++; $display("FAIL read_mem_re: offset %0d re %0d we %0d want 1 1 0", off, nre, nwe); end
      n_checks++; if ({rv, er, rd} !== {2'b01, 1'b0, 32'hDEAD_BEEF}) begin n_errors++; $display("FAIL read_rsp: valid %b err %b rdata %h want 01 0 deadbeef", rv, er, rd); end
   endtask

   task automatic test_write_read();
      int rlat, off, nre, nwe; logic [1:0] g, rv; logic [31:0] rd; logic er;
      do_access(1, 1'b1, 32'd7, 32'h1234_5678, 2, rlat, off, nre, nwe, g, rv, rd, er);
      n_checks++; if (g !== 2'b10 || rlat !== 4) begin n_errors++; $display("FAIL wr_gnt_lat: gnt %b lat %0d want 10 4", g, rlat); end
      n_checks++; if (nwe !== 1 || nre !== 0 || off !== 1) begin n_errors++; $display("FAIL wr_mem_we: we %0d re %0d offset %0d want 1 0 1", nwe, nre, off); end
      n_checks++; if ({rv, er, rd} !== {2'b10, 1'b0, 32'd0}) begin n_errors++; $display("FAIL wr_rsp: valid %b err %b rdata %h want 10 0 0", rv, er, rd); end
      do_access(0, 1'b0, 32'd7, 32'd0, 3, rlat, off, nre, nwe, g, rv, rd, er);
      n_checks++; if ({rv, er, rd} !== {2'b01, 1'b0, 32'h1234_5678} || rlat !== 5) begin n_errors++; $display("FAIL wr_readback: valid %b err %b rdata %h lat %0d want 01 0 12345678 5", rv, er, rd, rlat); end
   endtask

   task automatic test_out_of_range();
      int rlat, off, nre, nwe; logic [1:0] g, rv; logic [31:0] rd; logic er;
      do_access(0, 1'b0, 32'h0000_0400, 32'd0, 2, rlat, off, nre, nwe, g, rv, rd, er);
      n_checks++; if (g !== 2'b01 || rlat !== 1) begin n_errors++; $display("FAIL oor_gnt_lat: gnt %b lat %0d want 01 1", g, rlat); end
      n_checks++; if (nre + nwe !== 0) begin n_errors++; $display("FAIL oor_mem_touched: re %0d we %0d want 0 0", nre, nwe); end
      n_checks++; if ({rv, er, rd} !== {2'b01, 1'b1, 32'd0}) begin n_errors++; $display("FAIL oor_rsp: valid %b err %b rdata %h want 01 1 0", rv, er, rd); end
      do_access(1, 1'b1, 32'h8000_0005, 32'hFFFF_FFFF, 2, rlat, off, nre, nwe, g, rv, rd, er);
      n_checks++; if ({rv, er, rd} !== {2'b10, 1'b1, 32'd0} || rlat !== 1 || nre + nwe !== 0) begin n_errors++; $display("FAIL oor_wr: valid %b err %b rdata %h lat %0d ops %0d want 10 1 0 1 0", rv, er, rd, rlat, nre + nwe); end
   endtask

   task automatic test_timeout();
      int rlat, off, nre, nwe; logic [1:0] g, rv; logic [31:0] rd; logic er;
      do_access(0, 1'b0, 32'd3, 32'd0, 0, rlat, off, nre, nwe, g, rv, rd, er);
      n_checks++; if (rlat !== TIMEOUT + 2 || {rv, er, rd} !== {2'b01, 1'b1, 32'd0}) begin n_errors++; $display("FAIL tmo_silent: lat %0d valid %b err %b rdata %h want %0d 01 1 0", rlat, rv, er, rd, TIMEOUT + 2); end
      do_access(1, 1'b0, 32'd3, 32'd0, TIMEOUT, rlat, off, nre, nwe, g, rv, rd, er);
      n_checks++; if (rlat !== TIMEOUT + 2 || {rv, er, rd} !== {2'b10, 1'b0, init_val(3)}) begin n_errors++; $display("FAIL tmo_last_cycle: lat %0d valid %b err %b rdata %h want %0d 10 0 %h", rlat, rv, er, rd, TIMEOUT + 2, init_val(3)); end
      do_access(0, 1'b0, 32'd3, 32'd0, TIMEOUT + 1, rlat, off, nre, nwe, g, rv, rd, er);
      n_checks++; if (rlat !== TIMEOUT + 2 || {rv, er, rd} !== {2'b01, 1'b1, 32'd0}) begin n_errors++; $display("FAIL tmo_late_valid: lat %0d valid %b err %b rdata %h want %0d 01 1 0", rlat, rv, er, rd, TIMEOUT + 2); end
      do_access(0, 1'b0, 32'd3, 32'd0, 2, rlat, off, nre, nwe, g, rv, rd, er);
      n_checks++; if (rlat !== 4 || {rv, er, rd} !== {2'b01, 1'b0, init_val(3)}) begin n_errors++; $display("FAIL tmo_recover: lat %0d valid %b err %b rdata %h want 4 01 0 %h", rlat, rv, er, rd, init_val(3)); end
   endtask

   task automatic test_alternate();
      logic [1:0] exp_g, prev_g;
      int g_cnt, prev_c, n0, n1;
      apply_reset();
      mem_lat = 2;
      exp_g = 2'b01; prev_g = 2'b00; g_cnt = 0; prev_c = -1; n0 = 0; n1 = 0;
      @(posedge clk); #1;
      req = 2'b11; req_we = 2'b00; req_addr0 = 32'd16; req_addr1 = 32'd17;
      for (int k = 0; k < 60 && g_cnt < 8; k++) begin
         @(negedge clk);
         if (rsp_valid != 2'b00) begin
            n_checks++; if (rsp_valid !== prev_g || cyc - prev_c !== 4) begin n_errors++; $display("FAIL alt_rsp: valid %b after %0d cycles want %b after 4", rsp_valid, cyc - prev_c, prev_g); end
         end
         if (gnt != 2'b00) begin
            n_checks++; if (gnt !== exp_g) begin n_errors++; $display("FAIL alt_order: grant %0d got %b want %b", g_cnt, gnt, exp_g); end
            if (prev_c >= 0) begin
               n_checks++; if (cyc - prev_c !== 5) begin n_errors++; $display("FAIL alt_spacing: got %0d cycles want 5", cyc - prev_c); end
            end
            if (gnt[0]) n0++;
            if (gnt[1]) n1++;
            prev_c = cyc; prev_g = gnt; exp_g = ~exp_g; g_cnt++;
         end
         @(posedge clk); #1;
      end
      req = 2'b00;
      n_checks++; if (g_cnt !== 8) begin n_errors++; $display("FAIL alt_count: got %0d grants want 8", g_cnt); end
      n_checks++; if (n0 !== 4 || n1 !== 4) begin n_errors++; $display("FAIL alt_fair: port0 %0d port1 %0d want 4 4", n0, n1); end
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int stray, rlat, off, nre, nwe; logic [1:0] g, rv; logic [31:0] rd; logic er;
      apply_reset();
      mem_lat = 2;
      @(posedge clk); #1;
      req = 2'b01; req_we = 2'b00; req_addr0 = 32'd9;
      @(negedge clk);
      n_checks++; if (gnt !== 2'b01) begin n_errors++; $display("FAIL rmid_gnt: got %b want 01", gnt); end
      @(posedge clk); #1;
      req = 2'b00;
      @(negedge clk);
      n_checks++; if (mem_re !== 1'b1) begin n_errors++; $display("FAIL rmid_issue: mem_re %b want 1", mem_re); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if ({mem_addr, mem_re, mem_we, rsp_valid} !== 36'd0) begin n_errors++; $display("FAIL rmid_cleared: addr %h re %b we %b valid %b want 0", mem_addr, mem_re, mem_we, rsp_valid); end
      stray = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rsp_valid != 2'b00) stray++;
      end
      n_checks++; if (stray !== 0) begin n_errors++; $display("FAIL rmid_no_rsp: got %0d rsp_valid cycles want 0", stray); end
      @(posedge clk); #1;
      do_access(1, 1'b0, 32'd9, 32'd0, 2, rlat, off, nre, nwe, g, rv, rd, er);
      n_checks++; if (rlat !== 4 || {rv, er, rd} !== {2'b10, 1'b0, init_val(9)}) begin n_errors++; $display("FAIL rmid_next: lat %0d valid %b err %b rdata %h want 4 10 0 %h", rlat, rv, er, rd, init_val(9)); end
   endtask

   // Both ports issue random traffic; expectations come from a transaction model of the arbiter.
   task automatic test_random();
      int free_at, rsp_at, op_at, cur_lat, lat_l, ep, rsp_p, c, r;
      logic m_last, op_we, e_err, inr;
      logic [31:0] e_dat, v;
      logic [1:0] pend, e_gnt, e_rsp;
      logic p_we [2];
      logic [31:0] p_addr [2];
      logic [31:0] p_wd [2];
      apply_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 1024; i++) begin v = $urandom; mem_arr[i] = v; ref_mem[i] = v; end
      m_last = 1'b1; pend = 2'b00; free_at = 0; rsp_at = -1; op_at = -1; op_we = 1'b0;
      rsp_p = 0; e_err = 1'b0; e_dat = 32'd0; cur_lat = 2;
      for (int p = 0; p < 2; p++) begin p_we[p] = 1'b0; p_addr[p] = 32'd0; p_wd[p] = 32'd0; end
      for (int k = 0; k < 2000; k++) begin
         @(posedge clk); #1;
         c = cyc;
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && k < 1900 && $urandom_range(0, 2) == 0) begin
               pend[p]   = 1'b1;
               p_we[p]   = 1'($urandom_range(0, 1));
               p_addr[p] = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0000_0400) : 32'($urandom_range(0, 1023));
               p_wd[p]   = $urandom;
            end
         end
         req = pend; req_we = {p_we[1], p_we[0]};
         req_addr0 = p_addr[0]; req_addr1 = p_addr[1]; req_wdata0 = p_wd[0]; req_wdata1 = p_wd[1];
         if (c >= free_at) begin
            r = int'($urandom_range(0, 19));
            if (r < 14)       cur_lat = int'($urandom_range(1, 4));
            else if (r < 16)  cur_lat = TIMEOUT;
            else if (r == 16) cur_lat = TIMEOUT + 1;
            else if (r == 17) cur_lat = 0;
            else if (r == 18) cur_lat = TIMEOUT + 2;
            else              cur_lat = int'($urandom_range(5, TIMEOUT - 1));
            mem_lat = cur_lat;
         end
         @(negedge clk);
         e_gnt = 2'b00; ep = 0;
         if (c >= free_at && pend != 2'b00) begin
            ep = (pend == 2'b11) ? (m_last ? 0 : 1) : (pend[1] ? 1 : 0);
            e_gnt[ep] = 1'b1;
         end
         e_rsp = (c == rsp_at) ? (rsp_p == 1 ? 2'b10 : 2'b01) : 2'b00;
         n_checks++; if (gnt !== e_gnt) begin n_errors++; $display("FAIL rnd_gnt: cycle %0d got %b want %b", c, gnt, e_gnt); end
         n_checks++; if (rsp_valid !== e_rsp) begin n_errors++; $display("FAIL rnd_rsp_valid: cycle %0d got %b want %b", c, rsp_valid, e_rsp); end
         n_checks++; if ({mem_re, mem_we} !== {c == op_at && !op_we, c == op_at && op_we}) begin n_errors++; $display("FAIL rnd_mem_op: cycle %0d re/we got %b%b want %b%b", c, mem_re, mem_we, c == op_at && !op_we, c == op_at && op_we); end
         if (c == rsp_at) begin
            n_checks++; if ({rsp_err, rsp_rdata} !== {e_err, e_dat}) begin n_errors++; $display("FAIL rnd_rsp_data: cycle %0d err %b rdata %h want %b %h", c, rsp_err, rsp_rdata, e_err, e_dat); end
         end
         if (e_gnt != 2'b00) begin
            m_last = ep[0];
            inr = (p_addr[ep] >> ADDRW) == 32'd0;
            if (!inr) begin
               lat_l = 1; e_err = 1'b1; e_dat = 32'd0;
            end else if (cur_lat == 0 || cur_lat > TIMEOUT) begin
               lat_l = 2 + TIMEOUT; e_err = 1'b1; e_dat = 32'd0;
            end else begin
               lat_l = 2 + cur_lat; e_err = 1'b0;
               e_dat = p_we[ep] ? 32'd0 : ref_mem[p_addr[ep][9:0]];
            end
            if (inr && p_we[ep]) ref_mem[p_addr[ep][9:0]] = p_wd[ep];
            rsp_at = c + lat_l; free_at = c + lat_l + 1; rsp_p = ep;
            op_at = inr ? c + 1 : -1; op_we = p_we[ep];
            pend[ep] = 1'b0;
         end
      end
      req = 2'b00;
   endtask

   initial begin
      rst = 1'b1; req = 2'b00; req_we = 2'b00;
      req_addr0 = 32'd0; req_addr1 = 32'd0; req_wdata0 = 32'd0; req_wdata1 = 32'd0;
      test_reset();
      test_alternate();
      test_read();
      test_write_read();
      test_out_of_range();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
